// File: rtl/mem_write_arbiter_pkg.sv
// Shared types for the Renderer -> MemoryController write path.
//   MemoryWriteRequest : one write beat; WriteStrobe doubles as the valid bit
//   SRC_BVH / SRC_FB   : encodings used by grant_src and the round-robin pointer
package mem_write_arbiter_pkg;

  typedef struct packed {
    logic         WriteStrobe;
    logic [26:0]  Address;
    logic [127:0] Data;
  } MemoryWriteRequest;

  localparam logic SRC_BVH = 1'b0;
  localparam logic SRC_FB  = 1'b1;

endpackage

// File: rtl/mem_write_arbiter_if.sv
// Bus bundle between the two write producers, the arbiter and the memory
// controller write port.
//   bvh_req / fb_req : producer requests (WriteStrobe = valid)
//   bvh_full/fb_full : per-source FIFO full flags
//   out_req/out_ready: valid/ready handshake towards the memory controller
//   grant_src        : source of the request currently in out_req
//   drop_count       : saturating count of strobes lost to a full FIFO
//   idle             : nothing buffered and nothing presented
// The slave modport is the arbiter side, master is the producer/consumer side.
interface mem_write_arbiter_if #(parameter int DROP_W = 16);
  import mem_write_arbiter_pkg::*;

  MemoryWriteRequest bvh_req;
  MemoryWriteRequest fb_req;
  MemoryWriteRequest out_req;
  logic              bvh_full;
  logic              fb_full;
  logic              out_ready;
  logic              grant_src;
  logic [DROP_W-1:0] drop_count;
  logic              idle;

  modport slave (
    input  bvh_req, fb_req, out_ready,
    output bvh_full, fb_full, out_req, grant_src, drop_count, idle
  );

  modport master (
    output bvh_req, fb_req, out_ready,
    input  bvh_full, fb_full, out_req, grant_src, drop_count, idle
  );

endinterface

// File: rtl/write_req_fifo.sv
// Per-source request FIFO.
//   i_push/i_data : store i_data when not full (a push while full is ignored,
//                   even if the same cycle pops)
//   i_pop         : advance the read pointer when not empty
//   o_head        : entry at the read pointer
//   o_full        : registered, set when the count reaches FIFO_DEPTH
//   o_empty       : decode of the registered count
//   o_count       : occupancy, one bit wider than the pointers
module write_req_fifo
  import mem_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  MemoryWriteRequest           i_data,
  input  logic                        i_pop,
  output MemoryWriteRequest           o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int           AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(FIFO_DEPTH);

  MemoryWriteRequest r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_full;

  logic              w_push;
  logic              w_pop;
  logic [AW:0]       w_count_nxt;

  // Fullness is judged on the registered state only, so a pop never frees a
  // slot for a push in the same cycle.
  assign w_push      = i_push && !r_full;
  assign w_pop       = i_pop && (r_count != '0);
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mem_write_arbiter.sv
// Shares the MemoryController write port between BVH-builder and framebuffer
// writes. Each source feeds a write_req_fifo; a round-robin arbiter drains
// them into a one-entry output register handshaked with out_ready.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of mem_write_arbiter_if (requests, full flags,
//                out_req/out_ready, grant_src, drop_count, idle)
module mem_write_arbiter
  import mem_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_write_arbiter_if.slave   bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  MemoryWriteRequest r_out;
  logic              r_grant;
  logic              r_last;
  logic [DROP_W-1:0] r_drop;

  MemoryWriteRequest w_bvh_head, w_fb_head, w_head;
  logic              w_bvh_full, w_fb_full;
  logic              w_bvh_empty, w_fb_empty;
  logic [CW-1:0]     w_bvh_count, w_fb_count;
  logic              w_can_load;
  logic              w_pop_bvh, w_pop_fb;
  logic              w_drop_bvh, w_drop_fb;
  logic [1:0]        w_drop_inc;
  logic [DROP_W:0]   w_drop_sum;

  write_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_bvh_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.bvh_req.WriteStrobe),
    .i_data  (bus.bvh_req),
    .i_pop   (w_pop_bvh),
    .o_head  (w_bvh_head),
    .o_full  (w_bvh_full),
    .o_empty (w_bvh_empty),
    .o_count (w_bvh_count)
  );

  write_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fb_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.fb_req.WriteStrobe),
    .i_data  (bus.fb_req),
    .i_pop   (w_pop_fb),
    .o_head  (w_fb_head),
    .o_full  (w_fb_full),
    .o_empty (w_fb_empty),
    .o_count (w_fb_count)
  );

  // out_ready only matters while the register holds a valid request.
  assign w_can_load = !r_out.WriteStrobe || bus.out_ready;

  always_comb begin
    w_pop_bvh = 1'b0;
    w_pop_fb  = 1'b0;
    if (w_can_load) begin
      if (!w_bvh_empty && !w_fb_empty) begin
        if (r_last == SRC_FB) w_pop_bvh = 1'b1;
        else                  w_pop_fb  = 1'b1;
      end else if (!w_bvh_empty) begin
        w_pop_bvh = 1'b1;
      end else if (!w_fb_empty) begin
        w_pop_fb = 1'b1;
      end
    end
  end

  assign w_head = w_pop_fb ? w_fb_head : w_bvh_head;

  // Both sources may drop in one cycle, so the increment is 0..2; one extra
  // bit on the sum detects wrap and clamps to all-ones.
  assign w_drop_bvh = bus.bvh_req.WriteStrobe && w_bvh_full;
  assign w_drop_fb  = bus.fb_req.WriteStrobe && w_fb_full;
  assign w_drop_inc = {1'b0, w_drop_bvh} + {1'b0, w_drop_fb};
  assign w_drop_sum = {1'b0, r_drop} + (DROP_W+1)'(w_drop_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_grant <= SRC_BVH;
      r_last  <= SRC_FB;
      r_drop  <= '0;
    end else begin
      if (w_pop_bvh || w_pop_fb) begin
        r_out             <= w_head;
        r_out.WriteStrobe <= 1'b1;
        r_grant           <= w_pop_fb ? SRC_FB : SRC_BVH;
        r_last            <= w_pop_fb ? SRC_FB : SRC_BVH;
      end else if (bus.out_ready) begin
        // Accepted with nothing to refill: drop valid, keep address/data.
        r_out.WriteStrobe <= 1'b0;
      end
      r_drop <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
    end
  end

  assign bus.out_req    = r_out;
  assign bus.grant_src  = r_grant;
  assign bus.drop_count = r_drop;
  assign bus.bvh_full   = w_bvh_full;
  assign bus.fb_full    = w_fb_full;
  assign bus.idle       = w_bvh_empty && w_fb_empty && !r_out.WriteStrobe;

endmodule

// File: tb/tb_mem_write_arbiter.sv
module tb_mem_write_arbiter;
  import mem_write_arbiter_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_write_arbiter_if #(.DROP_W(DW)) bus ();

  mem_write_arbiter #(.FIFO_DEPTH(DEPTH), .DROP_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [26:0]  a;
    logic [127:0] d;
    logic         s;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [127:0] dpat(input logic [26:0] a);
    return {4{5'b0, a}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_req(input logic [26:0] a, input logic s);
    exp_t e;
    e.a = a; e.d = dpat(a); e.s = s;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of strobes, then release them.
  task automatic drive(input bit b, input logic [26:0] ab, input bit f, input logic [26:0] af);
    bus.bvh_req = '{WriteStrobe: b, Address: ab, Data: dpat(ab)};
    bus.fb_req  = '{WriteStrobe: f, Address: af, Data: dpat(af)};
    tick();
    bus.bvh_req = '0;
    bus.fb_req  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.out_req.WriteStrobe && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got addr %0h with nothing expected", bus.out_req.Address);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_addr", 128'(bus.out_req.Address), 128'(e.a));
        chk("out_data", bus.out_req.Data, e.d);
        chk("out_src",  128'(bus.grant_src), 128'(e.s));
      end
    end
  end

  initial begin
    bus.bvh_req   = '0;
    bus.fb_req    = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    ticks(2);
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 128'(bus.out_req.WriteStrobe), 0);
    chk("rst_addr",  128'(bus.out_req.Address), 0);
    chk("rst_grant", 128'(bus.grant_src), 0);
    chk("rst_drop",  128'(bus.drop_count), 0);
    chk("rst_idle",  128'(bus.idle), 1);
    chk("rst_full",  128'({bus.bvh_full, bus.fb_full}), 0);

    // 1. Single FB write, A5 data
    bus.out_ready = 1'b1;
    begin
      exp_t e;
      e.a = 27'h100; e.d = {16{8'hA5}}; e.s = SRC_FB;
      exp_q.push_back(e);
    end
    bus.fb_req = '{WriteStrobe: 1'b1, Address: 27'h100, Data: {16{8'hA5}}};
    tick();
    bus.fb_req = '0;
    chk("t1_not_yet", 128'(bus.out_req.WriteStrobe), 0);
    tick();
    chk("t1_valid", 128'(bus.out_req.WriteStrobe), 1);
    chk("t1_grant", 128'(bus.grant_src), 1);
    tick();
    chk("t1_one_cycle", 128'(bus.out_req.WriteStrobe), 0);
    chk("t1_idle", 128'(bus.idle), 1);

    // 2. Round robin: last grant was FB, so BVH wins the first tie
    for (int i = 0; i < 4; i++) begin
      expect_req(27'h10 + 27'(i), SRC_BVH);
      expect_req(27'h20 + 27'(i), SRC_FB);
    end
    for (int i = 0; i < 4; i++) drive(1, 27'h10 + 27'(i), 1, 27'h20 + 27'(i));
    ticks(8);
    chk("t2_drained", 128'(exp_q.size()), 0);
    chk("t2_idle", 128'(bus.idle), 1);

    // 3. Backpressure and overflow: 1 parked + 8 buffered + 1 dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) expect_req(27'h30 + 27'(i), SRC_BVH);
    for (int i = 0; i < 10; i++) drive(1, 27'h30 + 27'(i), 0, 27'h0);
    chk("t3_parked", 128'(bus.out_req.Address), 128'(27'h30));
    chk("t3_valid",  128'(bus.out_req.WriteStrobe), 1);
    chk("t3_full",   128'(bus.bvh_full), 1);
    chk("t3_drop",   128'(bus.drop_count), 1);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_full_fall", 128'(bus.bvh_full), 0);
    ticks(10);
    chk("t3_drained", 128'(exp_q.size()), 0);
    chk("t3_idle", 128'(bus.idle), 1);
    chk("t3_drop_hold", 128'(bus.drop_count), 1);

    // 4. Stall stability
    bus.out_ready = 1'b0;
    expect_req(27'h40, SRC_BVH);
    expect_req(27'h41, SRC_BVH);
    drive(1, 27'h40, 0, 27'h0);
    drive(1, 27'h41, 0, 27'h0);
    chk("t4_load", 128'(bus.out_req.Address), 128'(27'h40));
    tick();
    chk("t4_stall1", 128'(bus.out_req.Address), 128'(27'h40));
    tick();
    chk("t4_stall2", 128'(bus.out_req.Address), 128'(27'h40));
    chk("t4_stall_v", 128'(bus.out_req.WriteStrobe), 1);
    bus.out_ready = 1'b1;
    tick();
    chk("t4_next", 128'(bus.out_req.Address), 128'(27'h41));
    chk("t4_next_v", 128'(bus.out_req.WriteStrobe), 1);
    tick();
    chk("t4_empty_v", 128'(bus.out_req.WriteStrobe), 0);
    chk("t4_addr_hold", 128'(bus.out_req.Address), 128'(27'h41));
    chk("t4_drained", 128'(exp_q.size()), 0);

    // 5. Reset mid-operation: 1 parked + 5 queued FB entries
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(0, 27'h0, 1, 27'h50 + 27'(i));
    chk("t5_pre_valid", 128'(bus.out_req.WriteStrobe), 1);
    do_reset();
    chk("t5_valid", 128'(bus.out_req.WriteStrobe), 0);
    chk("t5_full",  128'(bus.fb_full), 0);
    chk("t5_drop",  128'(bus.drop_count), 0);
    chk("t5_idle",  128'(bus.idle), 1);
    bus.out_ready = 1'b1;
    ticks(12);
    chk("t5_no_stale", 128'(bus.idle), 1);

    // 6. Drop counter saturation with DROP_W=4
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) drive(0, 27'h0, 1, 27'h60 + 27'(i));
    chk("t6_full", 128'(bus.fb_full), 1);
    chk("t6_drop0", 128'(bus.drop_count), 0);
    for (int i = 0; i < 20; i++) drive(0, 27'h0, 1, 27'h70 + 27'(i));
    chk("t6_sat", 128'(bus.drop_count), 15);
    do_reset();
    chk("t6_rst_drop", 128'(bus.drop_count), 0);

    chk("final_queue", 128'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
